rle_video_encoder: RTL
======================

Name: rle_video_encoder

Overview:
- Converts a raster pixel stream (6-bit RRGGBB colour per pixel) into the 16-bit run-length words consumed by the RLE video playback path.
- Its output words are written to SPI flash by the image-preparation/programming path and read back by the decoder at scan-out.
- Sits between a pixel source (test pattern generator or host loader) and a word sink (flash page writer); valid/ready on both sides.

Parameters:
- COLOUR_BITS, 6, width of the colour field; occupies word bits [COLOUR_BITS-1:0].
- DATA_WIDTH, 16, output word width; the run field is word bits [DATA_WIDTH-1:COLOUR_BITS] (RUN_BITS = DATA_WIDTH-COLOUR_BITS = 10).
- LINE_WIDTH, 640, pixels per line; used only when RLE_LINE_BREAK_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- pix_valid  in  1  pixel offered
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- pix_colour  in  COLOUR_BITS  pixel colour
- pix_last  in  1  pixel is the final pixel of the frame
- out_valid  out  1  out_data holds an unaccepted word
- out_ready  in  1  sink accepts the word when out_valid && out_ready
- out_data  out  DATA_WIDTH  {run_length, colour}
- busy  out  1  high whenever state != IDLE or out_valid

Behaviour:
- Word format: run_length = pixel count, range 1..MAX_RUN, where MAX_RUN = 2^RUN_BITS-1 = 1023. Word 0x0000 (run 0) is the end-of-frame marker.
- Single output register. slot_free = !out_valid || out_ready. Loading the register sets out_valid; acceptance without a reload clears it. out_data is stable while out_valid && !out_ready.
- States:
  - IDLE: no run held.
  - RUN: cur_colour and count held.
  - FLUSH: final run pending.
  - EOF: end-of-frame marker pending.
- pix_ready = slot_free && (state == IDLE || state == RUN). pix_ready has no dependence on pix_colour.
- IDLE, accept pixel c: cur = c, count = 1. Go to FLUSH if pix_last, else RUN.
- RUN, accept pixel c:
  - If c == cur and count < MAX_RUN: count++.
  - Else: load {count, cur} into the output register, then set cur = c, count = 1.
  - Then, if pix_last, go to FLUSH; else stay in RUN.
- FLUSH, slot_free: load {count, cur}; go to EOF.
- EOF, slot_free: load 16'h0000; go to IDLE.
- Latency:
  - A run is emitted on the cycle after the pixel that terminates it is accepted.
  - The final run is emitted 1 cycle after pix_last is accepted; the marker no earlier than 1 cycle after that.
  - Minimum 2 idle-input cycles between frames.
- Runs cross line boundaries; only MAX_RUN splits a run (without the optional feature).
- A run of exactly 1023 then one more same-colour pixel gives words {1023,c} and then {1,c}.
- Back-to-back emit (RUN terminating) while out_valid && out_ready: the new word replaces the old in the same cycle and out_valid stays 1.
- Reset values: out_valid = 0, out_data = 0, state = IDLE, count = 0, cur = 0, busy = 0. pix_ready = 1 in the first cycle after reset.
- Reset mid-frame discards the held run and any pending word; no partial flush.
- Held out_valid with out_ready = 0 stalls all input indefinitely; no word is lost or duplicated.

Optional Feature:
- Macro RLE_LINE_BREAK_EN.
- Defined:
  - Internal column counter, 0..LINE_WIDTH-1; wraps to 0 after LINE_WIDTH-1 and resets to 0 after pix_last.
  - When the accepted pixel is the first pixel of a line (column 0) and state == RUN, the held run is emitted as if the colour had changed, so no word spans two lines.
  - The end-of-frame flush is unchanged.
- Undefined: no column counter; runs span lines freely.

Test Plan:
- Pixels A(0x3F)x5, B(0x03)x3 with last on the final B, out_ready = 1 → words 0x017F, 0x00C3, 0x0000, then busy = 0.
- 1030 pixels of 0x15 with last → 0xFFD5 (1023), 0x01D5 (7), 0x0000.
- Single pixel 0x2A with last → 0x006A, 0x0000; pix_ready low during FLUSH/EOF.
- Alternating 0x01/0x02, 4 pixels, out_ready held 0 for 10 cycles after the first word → pix_ready = 0, out_data held at 0x0041 throughout; on release the words 0x0041, 0x0082, 0x0041, 0x0082, 0x0000 follow in order with none dropped.
- rst_n low for 1 cycle mid-run (count = 50) → next frame of 0x0Cx2 with last yields 0x008C, 0x0000 only.
- RLE_LINE_BREAK_EN, LINE_WIDTH = 4, 8 pixels of 0x07 with last → 0x0107, 0x0107, 0x0000.

Source files
------------

// File: rtl/rle_video_encoder_if.sv
// Pixel-in / run-word-out handshake bundle for rle_video_encoder.
// master = encoder side, slave = pixel source plus word sink side.
interface rle_video_encoder_if #(
    parameter int COLOUR_BITS = 6,
    parameter int DATA_WIDTH  = 16
);
    logic                   pix_valid;
    logic                   pix_ready;
    logic [COLOUR_BITS-1:0] pix_colour;
    logic                   pix_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   busy;

    modport master (
        input  pix_valid, pix_colour, pix_last, out_ready,
        output pix_ready, out_valid, out_data, busy
    );

    modport slave (
        output pix_valid, pix_colour, pix_last, out_ready,
        input  pix_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/rle_video_encoder.sv
// Raster pixel stream to {run_length, colour} words, terminated by a 0x0000 end-of-frame marker.
// Define RLE_LINE_BREAK_EN to stop runs from spanning lines of LINE_WIDTH pixels.
module rle_video_encoder #(
    parameter int COLOUR_BITS = 6,
    parameter int DATA_WIDTH  = 16,
    parameter int LINE_WIDTH  = 640
) (
    input  logic                clk,
    input  logic                rst_n,
    rle_video_encoder_if.master bus
);
    localparam int RUN_BITS = DATA_WIDTH - COLOUR_BITS;
    localparam logic [RUN_BITS-1:0] MAX_RUN = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_EOF} state_t;

    state_t                 state;
    logic [COLOUR_BITS-1:0] cur;
    logic [RUN_BITS-1:0]    count;
    logic                   slot_free;
    logic                   accept;
    logic                   line_start;
    logic                   split;

    function automatic logic [DATA_WIDTH-1:0] pack_word(input logic [RUN_BITS-1:0] run,
                                                         input logic [COLOUR_BITS-1:0] colour);
        return {run, colour};
    endfunction

    assign slot_free     = !bus.out_valid || bus.out_ready;
    assign bus.pix_ready = slot_free && (state == S_IDLE || state == S_RUN);
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign bus.busy      = (state != S_IDLE) || bus.out_valid;
    assign split         = (bus.pix_colour != cur) || (count == MAX_RUN) || line_start;

`ifdef RLE_LINE_BREAK_EN
    localparam int COL_BITS = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(LINE_WIDTH - 1);

    logic [COL_BITS-1:0] col;

    // Column of the pixel currently offered; a new frame always starts at column 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
        end else if (accept) begin
            col <= (bus.pix_last || col == COL_LAST) ? '0 : col + 1'b1;
        end
    end

    assign line_start = (col == '0);
`else
    assign line_start = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cur           <= '0;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            // Acceptance empties the slot; any load below refills it in the same cycle.
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur   <= bus.pix_colour;
                        count <= RUN_BITS'(1);
                        state <= bus.pix_last ? S_FLUSH : S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (split) begin
                            bus.out_data  <= pack_word(count, cur);
                            bus.out_valid <= 1'b1;
                            cur           <= bus.pix_colour;
                            count         <= RUN_BITS'(1);
                        end else begin
                            count <= count + 1'b1;
                        end
                        state <= bus.pix_last ? S_FLUSH : S_RUN;
                    end
                end
                S_FLUSH: begin
                    if (slot_free) begin
                        bus.out_data  <= pack_word(count, cur);
                        bus.out_valid <= 1'b1;
                        state         <= S_EOF;
                    end
                end
                S_EOF: begin
                    if (slot_free) begin
                        bus.out_data  <= '0;
                        bus.out_valid <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
